pp_accumulator: RTL and testbench
=================================

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; product width is 2*WIDTH.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports are clk and rst.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  operand pair on a/b is valid.
REQ-006 Port: in_ready  output  1  block can accept an operand pair.
REQ-007 Port: a  input  WIDTH  unsigned multiplicand.
REQ-008 Port: b  input  WIDTH  unsigned multiplier; each bit selects one partial-product row.
REQ-009 Port: out_valid  output  1  product is valid.
REQ-010 Port: out_ready  input  1  consumer accepts product.
REQ-011 Port: product  output  2*WIDTH  unsigned a*b.
REQ-012 Port: busy  output  1  high in ACCUM or DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCUM, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in ACCUM and DONE it SHALL be 0.
REQ-015 On an edge with in_valid && in_ready, the block SHALL latch a and b, clear the accumulator, set row counter to 0, and enter ACCUM.
REQ-016 Each ACCUM edge SHALL add the row (b_reg[cnt] ? a_reg : 0) shifted left by cnt into a 2*WIDTH accumulator, then increment cnt.
REQ-017 The edge that adds row WIDTH-1 SHALL move the FSM to DONE; latency is exactly WIDTH cycles from the accept edge to out_valid high (16 for default).
REQ-018 Accumulation SHALL NOT terminate early on zero operand bits; latency is data-independent.
REQ-019 Arithmetic SHALL be unsigned; the 2*WIDTH accumulator never overflows, and no carry out is produced.
REQ-020 out_valid SHALL be 1 only in DONE; product SHALL stay stable while out_valid && !out_ready.
REQ-021 On an edge with out_valid && out_ready, the FSM SHALL return to IDLE, and in_ready rises the following cycle (no same-cycle bypass).
REQ-022 With out_ready held high, back-to-back throughput SHALL be one result per WIDTH+2 cycles.
REQ-023 In ACCUM and DONE, in_valid, a and b SHALL be ignored; no operand is captured or lost-state corrupted.
REQ-024 product SHALL equal the accumulator register at all times: it holds the last result in IDLE and clears on the next accept.

Reset
REQ-025 When rst is high at an edge, the block SHALL enter IDLE with cnt=0, accumulator, a_reg and b_reg all 0.
REQ-026 After reset: in_ready=1, out_valid=0, busy=0, product=0.
REQ-027 Reset asserted in ACCUM or DONE SHALL abort the operation; no out_valid SHALL be produced for the aborted pair.
REQ-028 rst SHALL take priority over all handshakes in the same cycle.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and the default WIDTH constant.
REQ-030 Row generation SHALL be one sub-module, pp_row_gen (WIDTH-bit AND of a_reg with the replicated selected b bit); the shift/add and FSM stay in pp_accumulator.
REQ-031 cnt width SHALL be clog2(WIDTH) bits.

Verification
REQ-032 a=0xFFFF, b=0xFFFF, out_ready=1 -> out_valid high 16 cycles after accept, product=0xFFFE0001.
REQ-033 a=0x1234, b=0x0000 -> product=0x00000000 after the full 16-cycle latency (no early finish).
REQ-034 a=0x00FF, b=0x0101, out_ready held low 5 cycles in DONE -> product=0x0000FFFF stable and out_valid high throughout; IDLE one cycle after out_ready rises.
REQ-035 in_valid pulsed with a=0x5555, b=0x2 at cycle 4 of an ACCUM for 3*7 -> first result 0x00000015, and the second pair is not captured.
REQ-036 rst high at cycle 8 of ACCUM -> next cycle in_ready=1, out_valid=0, product=0; a fresh 2*3 then yields 0x00000006.
REQ-037 Random back-to-back pairs with out_ready=1 -> accepts every 18 cycles, each product matching a reference model.

Source files
------------

// File: rtl/pp_accumulator_pkg.sv
// rtl/pp_accumulator_pkg.sv - shared state encoding and default width for the shift-add multiplier
package pp_accumulator_pkg;

  localparam int PP_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } pp_state_t;

endpackage

// File: rtl/pp_row_gen.sv
// rtl/pp_row_gen.sv - one partial-product row: a gated by the selected multiplier bit
module pp_row_gen #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
) (
  input  logic [WIDTH-1:0] a_reg,
  input  logic [WIDTH-1:0] b_reg,
  input  logic [CW-1:0]    sel,
  output logic [WIDTH-1:0] row
);

  assign row = a_reg & {WIDTH{b_reg[sel]}};

endmodule

// File: rtl/pp_accumulator.sv
// rtl/pp_accumulator.sv - sequential unsigned multiplier, one partial-product row per cycle
module pp_accumulator
  import pp_accumulator_pkg::*;
#(
  parameter int WIDTH = PP_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

  pp_state_t        state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, row;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic             accept;
  logic             last_row;

  pp_row_gen #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_row_gen (
    .a_reg (a_reg),
    .b_reg (b_reg),
    .sel   (cnt),
    .row   (row)
  );

  assign last_row = (cnt == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (last_row) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Every row is added, even zero ones, so latency never depends on b.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == S_ACCUM) begin
      acc <= acc + ({{WIDTH{1'b0}}, row} << cnt);
      if (!last_row) cnt <= cnt + 1'b1;
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_pp_accumulator.sv
// tb/tb_pp_accumulator.sv - randomized and directed checks of pp_accumulator against a*b
module tb_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pp_accumulator #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 64) begin
      step();
      k++;
    end
  endtask

  // Presents a pair for one edge; returns the cycle stamp taken just before the accept edge.
  task automatic accept_pair(input logic [15:0] av, input logic [15:0] bv, output int t_acc);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    t_acc    = cyc;
    step();
    in_valid = 1'b0;
  endtask

  logic [15:0] ra [10];
  logic [15:0] rb [10];
  int          t_acc, t_prev, k;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);

    // all-ones operands
    accept_pair(16'hFFFF, 16'hFFFF, t_acc);
    chk("ones_busy", busy, 1);
    chk("ones_in_ready", in_ready, 0);
    wait_done();
    chk("ones_latency", cyc - t_acc - 1, 16);
    chk("ones_product", product, 32'hFFFE0001);
    step();
    chk("ones_idle_ready", in_ready, 1);
    chk("ones_idle_valid", out_valid, 0);
    chk("ones_idle_hold", product, 32'hFFFE0001);

    // zero multiplier still takes the full latency
    accept_pair(16'h1234, 16'h0000, t_acc);
    chk("zero_clear", product, 0);
    wait_done();
    chk("zero_latency", cyc - t_acc - 1, 16);
    chk("zero_product", product, 0);
    step();

    // consumer stalls in DONE
    out_ready = 1'b0;
    accept_pair(16'h00FF, 16'h0101, t_acc);
    wait_done();
    chk("stall_latency", cyc - t_acc - 1, 16);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_product", product, 32'h0000FFFF);
      step();
    end
    out_ready = 1'b1;
    chk("stall_release_valid", out_valid, 1);
    step();
    chk("stall_idle_ready", in_ready, 1);
    chk("stall_idle_valid", out_valid, 0);

    // operands offered mid-accumulation are ignored
    accept_pair(16'd3, 16'd7, t_acc);
    step(); step(); step();
    a = 16'h5555; b = 16'h0002; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done();
    chk("ignore_latency", cyc - t_acc - 1, 16);
    chk("ignore_product", product, 32'h00000015);
    step();
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) break;
      step();
    end
    chk("ignore_no_second", out_valid, 0);
    chk("ignore_idle_busy", busy, 0);

    // reset aborts an operation in progress
    accept_pair(16'hABCD, 16'h1357, t_acc);
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_product", product, 0);
    chk("abort_busy", busy, 0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) k++;
      step();
    end
    chk("abort_no_result", k, 0);

    // reset wins over a same-cycle accept
    rst = 1'b1; a = 16'h0005; b = 16'h0005; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_ready", in_ready, 1);

    accept_pair(16'd2, 16'd3, t_acc);
    wait_done();
    chk("fresh_latency", cyc - t_acc - 1, 16);
    chk("fresh_product", product, 32'h00000006);
    step();

    // random back-to-back pairs; operands change while the block is busy
    for (int i = 0; i < 10; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
    end
    ra[1] = 16'hFFFF; rb[1] = 16'h8000;
    out_ready = 1'b1;
    a = ra[0]; b = rb[0]; in_valid = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 10; i++) begin
      k = 0;
      while (in_ready !== 1'b1 && k < 64) begin
        step();
        k++;
      end
      chk("rnd_ready", in_ready, 1);
      if (i > 0) chk("rnd_interval", cyc - t_prev, 18);
      t_prev = cyc;
      step();
      if (i + 1 < 10) begin
        a = ra[i+1];
        b = rb[i+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_done();
      chk("rnd_latency", cyc - t_prev - 1, 16);
      chk("rnd_product", product, 64'(ra[i]) * 64'(rb[i]));
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
